boot_seq: RTL
=============

BOOT_SEQ -- requirements
Module: boot_seq

Interface
REQ-001 Parameters: MEM_WORDS, default 256, core memory words loadable; OUT_DEPTH, default 32, output-capture FIFO depth; MAX_CYCLES, default 100000, run watchdog limit; RST_CYCLES, default 2, core-reset hold length.
REQ-002 Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-low reset.
- ld_valid  in  1  host program-word valid.
- ld_ready  out  1  block accepts a program word.
- ld_data  in  32  program word.
- ld_last  in  1  final program word.
- start  in  1  one-cycle run request.
- core_rst  out  1  active-high reset to core.
- oob_wen  out  1  core memory write enable.
- oob_wr_addr  out  32  core memory word address.
- oob_wr_data  out  32  core memory write data.
- core_out  in  32  core output word.
- core_outen  in  1  core_out valid.
- core_halt  in  1  core halted.
- out_rd  in  1  pop capture FIFO.
- out_data  out  32  FIFO head, valid when out_empty=0.
- out_empty  out  1  FIFO empty.
- out_count  out  $clog2(OUT_DEPTH)+1  FIFO occupancy.
- state  out  3  current FSM state.
- done  out  1  run finished.
- timeout  out  1  run ended by watchdog.
- overflow  out  1  sticky, capture word dropped.
- cycle_cnt  out  32  core cycles in current/last run.

Function
REQ-003 States: IDLE, LOAD, LOADED, CORE_RST, RUN, DONE.
REQ-004 core_rst=1 in all states except RUN.
REQ-005 ld_ready=1 in IDLE, LOAD, LOADED, DONE; 0 in CORE_RST and RUN.
REQ-006 Accepted beat (ld_valid & ld_ready): next cycle oob_wen=1, oob_wr_data=ld_data, oob_wr_addr=word index, one write per beat.
REQ-007 Word index resets to 0 on entry to LOAD from IDLE, LOADED or DONE, increments per beat, and never exceeds MEM_WORDS-1.
REQ-008 First accepted beat from IDLE/LOADED/DONE -> LOAD; FIFO cleared, done/timeout/overflow cleared, cycle_cnt=0.
REQ-009 Accepted beat with ld_last=1, or at index MEM_WORDS-1 -> LOADED; further words go to a new load at index 0.
REQ-010 start ignored in IDLE, LOAD, CORE_RST, RUN; in LOADED or DONE -> CORE_RST.
REQ-011 CORE_RST lasts exactly RST_CYCLES cycles, then RUN; cycle_cnt cleared on CORE_RST entry.
REQ-012 RUN: cycle_cnt +1 per cycle, saturating at 2^32-1.
REQ-013 core_outen=1 in RUN pushes core_out into FIFO; core_outen outside RUN ignored.
REQ-014 Push with FIFO full and no pop: word dropped, overflow set; push+pop same cycle when full: both happen, no overflow.
REQ-015 core_halt in RUN -> DONE next cycle, done=1; outen in the halt cycle is still captured.
REQ-016 Pop with FIFO empty: no effect; pops are legal in every state.
REQ-017 start and ld_valid together in LOADED/DONE: load wins.

Reset
REQ-018 rst=0 mid-operation: state=IDLE, core_rst=1, oob_wen=0, oob_wr_addr=0, oob_wr_data=0, FIFO empty, out_count=0, done/timeout/overflow=0, cycle_cnt=0, all at the next clk edge.

Configuration
REQ-019 BOOT_SEQ_TIMEOUT_EN defined: in RUN, cycle_cnt reaching MAX_CYCLES -> DONE with timeout=1, done=1; halt in the same cycle wins, so timeout=0.
REQ-020 BOOT_SEQ_TIMEOUT_EN undefined: no watchdog, timeout tied 0, RUN exits only on core_halt or reset.

Structure
REQ-021 Package boot_seq_pkg holds the state enum, default MEM_WORDS, OUT_DEPTH, MAX_CYCLES, RST_CYCLES.
REQ-022 FIFO is a sub-module boot_seq_fifo: synchronous, first-word fall-through, width 32, depth OUT_DEPTH.

Verification
REQ-023 Load 3 words A0,A1,A2 (last on third) -> oob writes addr 0,1,2 with matching data; state LOADED.
REQ-024 start; core emits 0x11, 0x22, then halt -> core_rst low after 2 cycles; FIFO holds 0x11, 0x22; done=1; out_count=2.
REQ-025 Core emits 33 words with no pops (OUT_DEPTH 32) -> out_count=32, overflow=1, first 32 words intact.
REQ-026 BOOT_SEQ_TIMEOUT_EN, MAX_CYCLES=50, no halt -> DONE after 50 RUN cycles, timeout=1, cycle_cnt=50.
REQ-027 rst=0 during RUN after 10 words captured -> next cycle IDLE, core_rst=1, out_empty=1, done=0.
REQ-028 start in DONE -> rerun without reload; same outputs captured; overflow unchanged until new load.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// rtl/boot_seq_pkg.sv - boot sequencer defaults and state encoding
package boot_seq_pkg;

  localparam int DEF_MEM_WORDS  = 256;
  localparam int DEF_OUT_DEPTH  = 32;
  localparam int DEF_MAX_CYCLES = 100000;
  localparam int DEF_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_LOADED   = 3'd2,
    S_CORE_RST = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/boot_seq_fifo.sv
// rtl/boot_seq_fifo.sv - first-word fall-through capture FIFO with drop flag
module boot_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & ~do_push;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_q];
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/boot_seq.sv
// rtl/boot_seq.sv - program loader, core reset/run sequencer and output capture
// Optional run watchdog enabled by defining BOOT_SEQ_TIMEOUT_EN.
module boot_seq
  import boot_seq_pkg::*;
#(
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int OUT_DEPTH  = DEF_OUT_DEPTH,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [31:0]                  ld_data,
  input  logic                         ld_last,
  input  logic                         start,
  output logic                         core_rst,
  output logic                         oob_wen,
  output logic [31:0]                  oob_wr_addr,
  output logic [31:0]                  oob_wr_data,
  input  logic [31:0]                  core_out,
  input  logic                         core_outen,
  input  logic                         core_halt,
  input  logic                         out_rd,
  output logic [31:0]                  out_data,
  output logic                         out_empty,
  output logic [$clog2(OUT_DEPTH):0]   out_count,
  output logic [2:0]                   state,
  output logic                         done,
  output logic                         timeout,
  output logic                         overflow,
  output logic [31:0]                  cycle_cnt
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, beat_idx;
  logic [31:0]   rcnt_q, rcnt_d, cyc_q, cyc_d;
  logic          done_q, done_d, tmo_q, tmo_d, ovf_q, ovf_d;
  logic          wen_q, wen_d;
  logic [31:0]   waddr_q, waddr_d, wdata_q, wdata_d;
  logic          accept, fresh, fifo_clr, fifo_push, fifo_drop;

  assign ld_ready  = (state_q != S_CORE_RST) && (state_q != S_RUN);
  assign accept    = ld_valid & ld_ready;
  assign fresh     = (state_q != S_LOAD);
  assign beat_idx  = fresh ? '0 : idx_q;
  assign fifo_clr  = accept & fresh;
  assign fifo_push = (state_q == S_RUN) & core_outen;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    ovf_d   = ovf_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // A host beat outranks start, so a load always begins from a clean slate.
    if (accept) begin
      wen_d   = 1'b1;
      waddr_d = 32'(beat_idx);
      wdata_d = ld_data;
      idx_d   = (beat_idx == IW'(MEM_WORDS - 1)) ? beat_idx : beat_idx + 1'b1;
      state_d = (ld_last || beat_idx == IW'(MEM_WORDS - 1)) ? S_LOADED : S_LOAD;
      if (fresh) begin
        done_d = 1'b0;
        tmo_d  = 1'b0;
        ovf_d  = 1'b0;
        cyc_d  = '0;
      end
    end else begin
      case (state_q)
        S_LOADED, S_DONE: begin
          if (start) begin
            state_d = S_CORE_RST;
            rcnt_d  = '0;
            cyc_d   = '0;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
          end
        end
        S_CORE_RST: begin
          if (rcnt_q == 32'(RST_CYCLES - 1)) state_d = S_RUN;
          else rcnt_d = rcnt_q + 1;
        end
        S_RUN: begin
          if (cyc_q != '1) cyc_d = cyc_q + 1;
          if (core_halt) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
`ifdef BOOT_SEQ_TIMEOUT_EN
          else if (cyc_d == 32'(MAX_CYCLES)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            tmo_d   = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      ovf_q   <= ovf_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

`ifndef BOOT_SEQ_TIMEOUT_EN
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
`endif

  boot_seq_fifo #(.WIDTH(32), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rstn_i      (rst),
    .clr_i       (fifo_clr),
    .push_i      (fifo_push),
    .push_data_i (core_out),
    .pop_i       (out_rd),
    .pop_data_o  (out_data),
    .empty_o     (out_empty),
    .count_o     (out_count),
    .drop_o      (fifo_drop)
  );

  assign core_rst    = (state_q != S_RUN);
  assign oob_wen     = wen_q;
  assign oob_wr_addr = waddr_q;
  assign oob_wr_data = wdata_q;
  assign state       = state_q;
  assign done        = done_q;
  assign timeout     = tmo_q;
  assign overflow    = ovf_q;
  assign cycle_cnt   = cyc_q;

endmodule
